// File: rtl/control_pkg.sv
// control_pkg -- shared encodings for the main instruction decoder.
//   Opcode constants for every instruction class that is decoded.
//   Encodings for the alu_op, mem_to_reg and jump fields.
//   ctrl_t bundles all decoded control fields. Other files use it to carry
//   the decoder result into the output register.
package control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,  // address generation
        ALU_BRANCH = 2'b01,  // branch compare
        ALU_RTYPE  = 2'b10,  // funct3/funct7 select the operation
        ALU_ITYPE  = 2'b11   // funct3 selects the operation
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11     // never produced
    } wb_sel_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_JAL  = 2'b01,
        JMP_JALR = 2'b10,
        JMP_RSVD = 2'b11    // never produced
    } jump_e;

    typedef struct packed {
        logic    alu_src;
        logic    branch;
        logic    mem_read;
        wb_sel_e mem_to_reg;
        logic    reg_write;
        logic    mem_write;
        alu_op_e alu_op;
        jump_e   jump;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// control_decode -- purely combinational opcode decoder.
//   opcode : RISC-V instruction bits [6:0]
//   ctrl   : next value of every control output
// Any opcode that does not match the table goes to the safe default. This
// includes opcodes with X or Z bits, because a plain case never matches
// those. In the safe default, every write or enable is 0 and illegal is 1.
module control_decode
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl            = '0;
        ctrl.mem_to_reg = WB_ALU;
        ctrl.alu_op     = ALU_ADD;
        ctrl.jump       = JMP_NONE;
        ctrl.illegal    = 1'b1;
        case (opcode)
            OP_R: begin
                ctrl.illegal   = 1'b0;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_RTYPE;
            end
            OP_IMM: begin
                ctrl.illegal   = 1'b0;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ITYPE;
            end
            OP_LOAD: begin
                ctrl.illegal    = 1'b0;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = WB_MEM;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
            end
            OP_STORE: begin
                ctrl.illegal   = 1'b0;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.illegal = 1'b0;
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = ALU_BRANCH;
            end
            OP_JAL: begin
                ctrl.illegal    = 1'b0;
                ctrl.mem_to_reg = WB_PC4;
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = JMP_JAL;
            end
            OP_JALR: begin
                ctrl.illegal    = 1'b0;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = WB_PC4;
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = JMP_JALR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control.sv
// control -- registered main decoder. Outputs follow the opcode one cycle later.
//   clk, rst_n  : clock and asynchronous active-low reset. While reset is
//                 asserted, all outputs are 0, including illegal.
//   opcode      : instruction bits [6:0], sampled on each rising edge
//   alu_src, branch, mem_read, mem_to_reg, reg_write, mem_write, alu_op,
//   jump, illegal : registered control fields
// The outputs come straight from flops, so there is no combinational path
// from opcode to any output.
module control
    import control_pkg::*;
(
    output logic       alu_src,
    output logic       branch,
    output logic       mem_read,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       mem_write,
    output logic [1:0] alu_op,
    input  logic [6:0] opcode,
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] jump,
    output logic       illegal
);

    ctrl_t dec;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode (opcode),
        .ctrl   (dec)
    );

    always_comb begin
        ctrl_d = dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrl_q <= '0;
        else        ctrl_q <= ctrl_d;
    end

    assign alu_src    = ctrl_q.alu_src;
    assign branch     = ctrl_q.branch;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_write  = ctrl_q.mem_write;
    assign alu_op     = ctrl_q.alu_op;
    assign jump       = ctrl_q.jump;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control.sv
// tb_control -- directed and random checks of the registered decoder against
// a rule-based reference model.
module tb_control;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [6:0] opcode;
    logic       alu_src, branch, mem_read, reg_write, mem_write, illegal;
    logic [1:0] mem_to_reg, alu_op, jump;

    int checks = 0;
    int errors = 0;

    control dut (
        .alu_src    (alu_src),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
        .opcode     (opcode),
        .clk        (clk),
        .rst_n      (rst_n),
        .jump       (jump),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk; else clk = 1'b0;

    // Output bundle packed in port order: alu_src, branch, mem_read,
    // mem_to_reg, reg_write, mem_write, alu_op, jump, illegal.
    function automatic logic [11:0] outs();
        return {alu_src, branch, mem_read, mem_to_reg, reg_write, mem_write,
                alu_op, jump, illegal};
    endfunction

    // Reference: expressed as instruction-class membership rules
    function automatic logic [11:0] model(input logic [6:0] op);
        bit r, im, ld, st, br, jl, jr, legal;
        logic [1:0] wb, aop, jmp;
        r  = (op === 7'b0110011);
        im = (op === 7'b0010011);
        ld = (op === 7'b0000011);
        st = (op === 7'b0100011);
        br = (op === 7'b1100011);
        jl = (op === 7'b1101111);
        jr = (op === 7'b1100111);
        legal = r | im | ld | st | br | jl | jr;
        wb  = (jl | jr) ? 2'd2 : (ld ? 2'd1 : 2'd0);
        aop = r ? 2'd2 : (im ? 2'd3 : (br ? 2'd1 : 2'd0));
        jmp = jl ? 2'd1 : (jr ? 2'd2 : 2'd0);
        return {im | ld | st | jr, br, ld, wb, r | im | ld | jl | jr, st,
                aop, jmp, !legal};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs,
                         input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive op away from the edge, clock it in, check just after the edge
    task automatic step(input string tag, input logic [6:0] op);
        @(negedge clk);
        opcode = op;
        @(posedge clk);
        #1;
        check(tag, outs(), model(op));
    endtask

    logic [6:0] seq [7] = '{7'b0110011, 7'b0100011, 7'b0010011, 7'b0000011,
                            7'b1100011, 7'b1101111, 7'b1100111};
    logic [6:0] op;
    logic [6:0] prev_op;

    initial begin
        // Reset applied with the clock stopped: outputs must already be 0
        clk_en = 1'b0;
        rst_n  = 1'b0;
        opcode = 7'b0110011;
        #3;
        check("reset_no_clk", outs(), 12'b0);
        clk_en = 1'b1;
        #12;
        check("reset_held_clk", outs(), 12'b0);

        // Release between edges; the first edge loads the R-type decode
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_first_edge", outs(), model(7'b0110011));
        check_bit("release_reg_write", reg_write, 1'b1);

        // The seven legal opcodes, one per edge
        foreach (seq[i]) step($sformatf("seq%0d_%b", i, seq[i]), seq[i]);
        check_bit("jalr_jump10", jump == 2'b10, 1'b1);

        // Illegal opcodes
        step("illegal_7f", 7'b1111111);
        check_bit("illegal_7f_flag", illegal, 1'b1);
        step("illegal_x", 7'bxxxxxxx);
        check_bit("illegal_x_regw", reg_write, 1'b0);
        step("illegal_zero", 7'b0000000);

        // Toggle the opcode between edges; outputs must hold until the edge
        step("toggle_base", 7'b0000011);
        opcode = 7'b0100011;
        #2;
        check("toggle_hold1", outs(), model(7'b0000011));
        opcode = 7'b1101111;
        #3;
        check("toggle_hold2", outs(), model(7'b0000011));
        opcode = 7'b0010011;
        @(posedge clk);
        #1;
        check("toggle_sampled", outs(), model(7'b0010011));

        // Random opcodes with the full reference model and the invariants
        // checked on every cycle
        prev_op = 7'b0010011;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 1) == 0) op = seq[$urandom_range(0, 6)];
            else                           op = 7'($urandom);
            step("rand", op);
            check_bit("inv_mem_rw", mem_read & mem_write, 1'b0);
            check_bit("inv_br_jmp", branch & (jump != 2'b00), 1'b0);
            check_bit("inv_ill_regw", illegal & reg_write, 1'b0);
            prev_op = op;
        end

        // Reset asserted mid-cycle clears the outputs at once and holds them
        step("pre_reset", 7'b1101111);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_now", outs(), 12'b0);
        @(posedge clk);
        #1;
        check("midreset_held", outs(), 12'b0);
        @(negedge clk);
        rst_n = 1'b1;
        opcode = 7'b0100011;
        @(posedge clk);
        #1;
        check("post_reset_store", outs(), model(7'b0100011));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety bound on total runtime
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 clk  input  1  rising-edge clock; the only clock in the block.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  7  RISC-V instruction bits [6:0].
REQ-004 alu_src  output  1  ALU operand B select: 0 = register rs2, 1 = immediate.
REQ-005 branch  output  1  conditional-branch instruction.
REQ-006 mem_read  output  1  data-memory read enable.
REQ-007 mem_to_reg  output  2  writeback select: 00 = ALU result, 01 = memory data, 10 = PC+4, 11 = reserved (never driven).
REQ-008 reg_write  output  1  register-file write enable.
REQ-009 mem_write  output  1  data-memory write enable.
REQ-010 alu_op  output  2  ALU class: 00 = add (address), 01 = branch compare, 10 = R-type (funct3/funct7), 11 = I-type ALU (funct3).
REQ-011 jump  output  2  00 = none, 01 = jal, 10 = jalr, 11 = never driven.
REQ-012 illegal  output  1  high when the opcode is not in the decode table.
REQ-013 Positional port order: alu_src, branch, mem_read, mem_to_reg, reg_write, mem_write, alu_op, opcode, clk, rst_n, jump, illegal.

Function
REQ-014 All outputs are registered; each rising clk edge samples opcode and loads the decoded values, so latency is 1 cycle.
REQ-015 R-type 0110011: alu_src=0, mem_to_reg=00, reg_write=1, mem_read=0, mem_write=0, branch=0, alu_op=10, jump=00.
REQ-016 I-ALU 0010011: alu_src=1, mem_to_reg=00, reg_write=1, mem_read=0, mem_write=0, branch=0, alu_op=11, jump=00.
REQ-017 Load 0000011: alu_src=1, mem_to_reg=01, reg_write=1, mem_read=1, mem_write=0, branch=0, alu_op=00, jump=00.
REQ-018 Store 0100011: alu_src=1, mem_to_reg=00, reg_write=0, mem_read=0, mem_write=1, branch=0, alu_op=00, jump=00.
REQ-019 Branch 1100011: alu_src=0, mem_to_reg=00, reg_write=0, mem_read=0, mem_write=0, branch=1, alu_op=01, jump=00.
REQ-020 JAL 1101111: alu_src=0, mem_to_reg=10, reg_write=1, mem_read=0, mem_write=0, branch=0, alu_op=00, jump=01.
REQ-021 JALR 1100111: alu_src=1, mem_to_reg=10, reg_write=1, mem_read=0, mem_write=0, branch=0, alu_op=00, jump=10.
REQ-022 Any other opcode, including X/Z bits: all control outputs 0 and illegal=1, so no state-changing write occurs.
REQ-023 Invariants on every cycle: mem_read and mem_write are never both 1; branch and jump!=00 are never both 1; illegal=1 implies reg_write=0.
REQ-024 An opcode change coincident with a clock edge takes the value sampled at that edge; there is no combinational path from opcode to any output.

Reset
REQ-025 While rst_n=0, all outputs are 0 immediately, independent of clk, and illegal=0.
REQ-026 The first rising edge with rst_n=1 loads the decode of the current opcode; reset release has no other side effects.
REQ-027 Reset asserted mid-stream clears outputs at once; the previous decode is not retained.

Structure
REQ-028 Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR), alu_op encodings, mem_to_reg encodings and jump encodings live in a shared package control_pkg.
REQ-029 A combinational sub-module control_decode (opcode to the next value of every output) feeds one output register stage in control.

Verification
REQ-030 rst_n=0 with opcode=0110011 -> all outputs 0 with no clock; release, one edge -> reg_write=1, alu_op=10, alu_src=0.
REQ-031 Sequence 0110011, 0100011, 0010011, 0000011, 1100011, 1101111, 1100111, one per edge -> each next cycle matches REQ-015 to REQ-021 (e.g. store: mem_write=1, reg_write=0; jalr: mem_to_reg=10, jump=10).
REQ-032 opcode=1111111 and then 7'bx -> illegal=1, reg_write=0, mem_write=0.
REQ-033 Opcode toggled between clock edges -> outputs change only at rising edges and hold for the full cycle.
REQ-034 Random opcodes for 1000 cycles -> REQ-023 invariants hold on every cycle.
